// File: rtl/tick_stopwatch_if.sv
// Command/display bundle between the stopwatch and its controller: tick and command
// levels in, BCD display value and status flags out.
interface tick_stopwatch_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  tick;
  logic                  start_stop;
  logic                  lap;
  logic                  clear;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  running;
  logic                  lap_active;
  logic                  overflow;

  modport master (
    output tick, start_stop, lap, clear,
    input  bcd_out, running, lap_active, overflow
  );

  modport slave (
    input  tick, start_stop, lap, clear,
    output bcd_out, running, lap_active, overflow
  );
endinterface

// File: rtl/tick_stopwatch.sv
// Cascaded BCD stopwatch counting prescaler ticks, with run/pause, lap hold and clear
// commands, sticky wrap overflow and a registered display value.
module tick_stopwatch #(
  parameter int unsigned DIGITS = 4
) (
  input logic              clk,
  input logic              reset,
  tick_stopwatch_if.slave  bus
);

  localparam int unsigned W = 4 * DIGITS;

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   snap_q, snap_d;
  logic [W-1:0]   bcd_q, bcd_d;
  logic           lap_active_q, lap_active_d;
  logic           overflow_q, overflow_d;
  logic           running_q;
  logic           ss_hist_q, lap_hist_q, clear_hist_q;
  logic           ss_edge, lap_edge, clear_edge;
  logic [W:0]     inc;

  // Returns {carry_out, value + 1} with per-digit decimal carry.
  function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (c) begin
        if (v[4*k +: 4] == 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  always_comb begin
    ss_edge    = bus.start_stop & ~ss_hist_q;
    lap_edge   = bus.lap & ~lap_hist_q;
    clear_edge = bus.clear & ~clear_hist_q;
    inc        = bcd_inc(count_q);
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    snap_d       = snap_q;
    lap_active_d = lap_active_q;
    overflow_d   = overflow_q;

    if (clear_edge) begin
      state_d      = StIdle;
      count_d      = '0;
      lap_active_d = 1'b0;
      overflow_d   = 1'b0;
    end else begin
      // Counting follows the state at the start of the cycle, so a stop edge still counts.
      if (bus.tick && (state_q == StRun)) begin
        count_d = inc[W-1:0];
        if (inc[W]) overflow_d = 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (ss_edge) state_d = StRun;
        end
        StRun: begin
          if (ss_edge) begin
            state_d = StPause;
          end else if (lap_edge) begin
            if (lap_active_q) begin
              lap_active_d = 1'b0;
            end else begin
              snap_d       = count_d;
              lap_active_d = 1'b1;
            end
          end
        end
        StPause: begin
          if (ss_edge) begin
            state_d = StRun;
          end else if (lap_edge) begin
            lap_active_d = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    bcd_d = lap_active_d ? snap_d : count_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      count_q      <= '0;
      snap_q       <= '0;
      bcd_q        <= '0;
      lap_active_q <= 1'b0;
      overflow_q   <= 1'b0;
      running_q    <= 1'b0;
      ss_hist_q    <= 1'b0;
      lap_hist_q   <= 1'b0;
      clear_hist_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      snap_q       <= snap_d;
      bcd_q        <= bcd_d;
      lap_active_q <= lap_active_d;
      overflow_q   <= overflow_d;
      running_q    <= (state_d == StRun);
      ss_hist_q    <= bus.start_stop;
      lap_hist_q   <= bus.lap;
      clear_hist_q <= bus.clear;
    end
  end

  assign bus.bcd_out    = bcd_q;
  assign bus.running    = running_q;
  assign bus.lap_active = lap_active_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_tick_stopwatch.sv
// Bench for tick_stopwatch: 4-digit and 2-digit instances share one stimulus stream and are
// checked every cycle against an integer-arithmetic model, plus directed and table checks.
module tb_tick_stopwatch;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0, ss = 1'b0, lap = 1'b0, clr = 1'b0;

  always #5 clk = ~clk;

  tick_stopwatch_if #(.DIGITS(4)) bus4 ();
  tick_stopwatch_if #(.DIGITS(2)) bus2 ();

  assign bus4.tick = tick;
  assign bus4.start_stop = ss;
  assign bus4.lap = lap;
  assign bus4.clear = clr;
  assign bus2.tick = tick;
  assign bus2.start_stop = ss;
  assign bus2.lap = lap;
  assign bus2.clear = clr;

  tick_stopwatch #(.DIGITS(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
  tick_stopwatch #(.DIGITS(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  int checks = 0;
  int failures = 0;

  // Behavioural model: plain integer count per instance; mode 0=idle 1=run 2=pause.
  int m_count[2];
  int m_snap[2];
  int m_mode[2];
  bit m_lap[2];
  bit m_ovf[2];
  int m_mod[2] = '{10000, 100};
  bit p_ss, p_lap, p_clr;

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int div;
    r = '0;
    div = 1;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'((v / div) % 10);
      div = div * 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_update();
    bit e_ss, e_lap, e_clr, was_run;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_count[i] = 0; m_snap[i] = 0; m_mode[i] = 0; m_lap[i] = 0; m_ovf[i] = 0;
      end
      p_ss = 0; p_lap = 0; p_clr = 0;
      return;
    end
    e_ss  = ss && !p_ss;
    e_lap = lap && !p_lap;
    e_clr = clr && !p_clr;
    for (int i = 0; i < 2; i++) begin
      was_run = (m_mode[i] == 1);
      if (e_clr) begin
        m_mode[i] = 0; m_count[i] = 0; m_lap[i] = 0; m_ovf[i] = 0;
      end else begin
        if (tick && was_run) begin
          m_count[i] = m_count[i] + 1;
          if (m_count[i] == m_mod[i]) begin
            m_count[i] = 0;
            m_ovf[i] = 1;
          end
        end
        if (e_ss) begin
          m_mode[i] = (m_mode[i] == 1) ? 2 : 1;
        end else if (e_lap && m_mode[i] != 0) begin
          if (m_lap[i]) m_lap[i] = 0;
          else if (m_mode[i] == 1) begin
            m_snap[i] = m_count[i];
            m_lap[i] = 1;
          end
        end
      end
    end
    p_ss = ss; p_lap = lap; p_clr = clr;
  endtask

  task automatic check_models();
    logic [31:0] a_bcd;
    logic a_run, a_lap, a_ovf;
    string tag;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        a_bcd = 32'(bus4.bcd_out); a_run = bus4.running;
        a_lap = bus4.lap_active; a_ovf = bus4.overflow; tag = "d4";
      end else begin
        a_bcd = 32'(bus2.bcd_out); a_run = bus2.running;
        a_lap = bus2.lap_active; a_ovf = bus2.overflow; tag = "d2";
      end
      chk({tag, "_model_bcd"}, a_bcd, to_bcd(m_lap[i] ? m_snap[i] : m_count[i]));
      chk({tag, "_model_running"}, 32'(a_run), 32'(m_mode[i] == 1));
      chk({tag, "_model_lap"}, 32'(a_lap), 32'(m_lap[i]));
      chk({tag, "_model_ovf"}, 32'(a_ovf), 32'(m_ovf[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_models();
  endtask

  task automatic chk4(input string nm, input logic [15:0] b, input logic r, input logic la,
                      input logic o);
    chk({nm, "_bcd"}, 32'(bus4.bcd_out), 32'(b));
    chk({nm, "_running"}, 32'(bus4.running), 32'(r));
    chk({nm, "_lap"}, 32'(bus4.lap_active), 32'(la));
    chk({nm, "_ovf"}, 32'(bus4.overflow), 32'(o));
  endtask

  task automatic chk2(input string nm, input logic [7:0] b, input logic r, input logic la,
                      input logic o);
    chk({nm, "_bcd"}, 32'(bus2.bcd_out), 32'(b));
    chk({nm, "_running"}, 32'(bus2.running), 32'(r));
    chk({nm, "_lap"}, 32'(bus2.lap_active), 32'(la));
    chk({nm, "_ovf"}, 32'(bus2.overflow), 32'(o));
  endtask

  typedef struct {
    logic        t, s, l, c;
    logic [15:0] bcd;
    logic        run, lapa, ovf;
  } vec_t;

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0006, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0007, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0007, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0007, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0};

    // Reset held for three cycles.
    reset = 1'b1;
    repeat (3) step();
    chk4("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Start, then 25 ticks at 1-in-10; start_stop held high for the first 50 cycles.
    for (int c = 0; c < 250; c++) begin
      ss = (c < 50);
      tick = (c % 10 == 9);
      step();
    end
    ss = 1'b0; tick = 1'b0;
    chk4("count25", 16'h0025, 1'b1, 1'b0, 1'b0);

    lap = 1'b1; step(); lap = 1'b0;
    chk4("lap_capture", 16'h0025, 1'b1, 1'b1, 1'b0);
    for (int j = 0; j < 24; j++) begin
      tick = (j % 2 == 1);
      step();
    end
    tick = 1'b0;
    chk4("lap_frozen", 16'h0025, 1'b1, 1'b1, 1'b0);
    lap = 1'b1; step(); lap = 1'b0;
    chk4("lap_release", 16'h0037, 1'b1, 1'b0, 1'b0);

    ss = 1'b1; step(); ss = 1'b0;
    chk4("pause", 16'h0037, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 10; j++) begin
      tick = (j % 2 == 1);
      step();
    end
    chk4("pause_ticks", 16'h0037, 1'b0, 1'b0, 1'b0);
    ss = 1'b1; tick = 1'b1; step();
    chk4("resume_tick", 16'h0037, 1'b1, 1'b0, 1'b0);
    ss = 1'b0; tick = 1'b0; step();
    tick = 1'b1; step(); tick = 1'b0;
    chk4("resume_next", 16'h0038, 1'b1, 1'b0, 1'b0);

    reset = 1'b1; step(); reset = 1'b0;
    chk4("reset_run", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Wrap on the 2-digit instance.
    ss = 1'b1; step(); ss = 1'b0;
    tick = 1'b1;
    repeat (99) step();
    chk2("d2_99", 8'h99, 1'b1, 1'b0, 1'b0);
    chk4("d4_99", 16'h0099, 1'b1, 1'b0, 1'b0);
    step();
    chk2("d2_wrap", 8'h00, 1'b1, 1'b0, 1'b1);
    chk4("d4_100", 16'h0100, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    tick = 1'b0;
    chk2("d2_after_wrap", 8'h03, 1'b1, 1'b0, 1'b1);

    clr = 1'b1; ss = 1'b1; lap = 1'b1; step();
    clr = 1'b0; ss = 1'b0; lap = 1'b0;
    chk2("d2_priority", 8'h00, 1'b0, 1'b0, 1'b0);
    chk4("d4_priority", 16'h0000, 1'b0, 1'b0, 1'b0);

    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tick = tbl[i].t; ss = tbl[i].s; lap = tbl[i].l; clr = tbl[i].c;
      step();
      chk4($sformatf("vec%0d", i), tbl[i].bcd, tbl[i].run, tbl[i].lapa, tbl[i].ovf);
    end

    // Random phase; the model is checked on every step inside step().
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 1499) == 0);
      tick = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) ss = ~ss;
      if ($urandom_range(0, 7) == 0) lap = ~lap;
      clr = ($urandom_range(0, 599) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_stopwatch.md
Name: tick_stopwatch

Overview:
- Downstream consumer of the PCounter prescaler: counts its single-cycle terminal-count pulse (`out`, here `tick`) as stopwatch time units.
- Holds a DIGITS-wide cascaded BCD count controlled by start/stop, lap and clear commands.
- Presents the count, or a frozen lap snapshot, to the display stage.
- Provides start/stop/lap/clear control plus wrap and overflow reporting.

Parameters:
- DIGITS, 4, number of cascaded BCD digits (1..8); count range 0 .. 10^DIGITS-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  time-unit pulse from the prescaler, one clk cycle wide, arbitrary spacing.
- start_stop  input  1  command level; each rising edge toggles run/pause.
- lap  input  1  command level; each rising edge toggles lap hold.
- clear  input  1  command level; rising edge returns to IDLE with zero count.
- bcd_out  output  4*DIGITS  displayed value; digit k at bits [4k+3:4k], digit 0 least significant.
- running  output  1  1 while state is RUN.
- lap_active  output  1  1 while bcd_out is frozen on a lap snapshot.
- overflow  output  1  sticky; set when the count wraps from all-9s to zero.

Behaviour:
- Reset (reset=1 at a clk edge): state IDLE, count=0, snapshot=0, bcd_out=0, running=0, lap_active=0, overflow=0, edge-detect history=0. Reset takes precedence over every other input, including mid-run.
- Command inputs are edge-detected internally against the previous-cycle sample.
  - Only 0->1 transitions act; a held level acts exactly once.
  - After reset the history is 0, so an input already high when reset releases counts as an edge on the first post-reset cycle.
- Same-cycle priority among commands: clear > start_stop > lap.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: start_stop edge -> RUN. lap is ignored.
  - RUN: start_stop edge -> PAUSE.
  - RUN: lap edge with lap_active=0 -> capture the snapshot and set lap_active=1.
  - RUN: lap edge with lap_active=1 -> clear lap_active.
  - PAUSE: start_stop edge -> RUN. lap edge clears lap_active if set; otherwise no effect.
  - Any state: clear edge -> IDLE, with count=0, lap_active=0, overflow=0. Any same-cycle tick is discarded.
- Counting uses the registered state at the start of the cycle.
  - count increments on an edge where tick=1 and the state is RUN.
  - tick coinciding with a start edge from IDLE/PAUSE is not counted.
  - tick coinciding with a stop edge from RUN is counted.
- Arithmetic is pure BCD.
  - A digit at 9 with carry-in goes to 0 and carries out.
  - All-9s plus a tick -> all-0s, and overflow is set on that same edge.
  - The count continues from zero afterwards. overflow stays 1 until clear or reset.
- Snapshot captures the next-count value, including any increment on the same edge.
- bcd_out selection and latency:
  - bcd_out = snapshot when lap_active=1, else count. It is a registered path; no combinational input-to-output path.
  - Latency: tick at edge N -> bcd_out shows the new value after edge N (same edge).
  - A lap release shows the live count after that edge.
- running = (state==RUN), registered with the state.

Test Plan:
- Reset: hold reset 3 cycles with all commands 0 -> bcd_out=0, running=0, lap_active=0, overflow=0. Then, with the state in RUN, assert reset for 1 cycle -> all outputs 0 on the next edge.
- Counting: start_stop rising edge, then 25 ticks at 1-in-10 spacing (PCounter p=10) -> bcd_out=16'h0025, running=1. Hold start_stop high for 50 cycles -> only one toggle.
- Lap hold: at count 0025, lap edge -> lap_active=1. Issue 12 ticks -> bcd_out stays 0025. Second lap edge -> bcd_out=0037, lap_active=0.
- Pause: stop edge at 0037, then 5 ticks -> bcd_out=0037, running=0. Start edge coincident with a tick -> still 0037; the next tick -> 0038.
- Overflow (DIGITS=2): from 0, issue 99 ticks -> 8'h99, overflow=0. One more tick -> 8'h00, overflow=1. 3 more ticks -> 8'h03, overflow still 1.
- Priority: clear, start_stop and lap edges in the same cycle while in RUN at 03 with overflow=1 -> IDLE, bcd_out=0, overflow=0, running=0.
